// File: rtl/layer_sequencer.sv
// Walks the layer configuration ROM from id 0 to NUM_LAYERS-1 and issues each
// registered layer descriptor to the compute engine (valid/ready in, done-pulse out).
module layer_sequencer #(
  parameter int NUM_LAYERS = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  rom_id,
  input  logic [19:0] rom_w_base,
  input  logic [11:0] rom_b_base,
  input  logic [2:0]  rom_layer_type,
  input  logic [10:0] rom_cin,
  input  logic [10:0] rom_cout,
  input  logic [7:0]  rom_img_w,
  input  logic [7:0]  rom_img_h,
  input  logic [1:0]  rom_stride,
  output logic        l_valid,
  input  logic        l_ready,
  input  logic        l_done,
  output logic [4:0]  l_id,
  output logic [19:0] l_w_base,
  output logic [11:0] l_b_base,
  output logic [2:0]  l_type,
  output logic [10:0] l_cin,
  output logic [10:0] l_cout,
  output logic [7:0]  l_in_w,
  output logic [7:0]  l_in_h,
  output logic [7:0]  l_out_w,
  output logic [7:0]  l_out_h,
  output logic [1:0]  l_stride,
  output logic        l_last
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_RUN, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam logic [4:0] LAST_ID = 5'(NUM_LAYERS - 1);

  state_t      r_state;
  logic        r_busy, r_done, r_err, r_valid, r_last;
  logic [4:0]  r_rom_id, r_l_id;
  logic [19:0] r_w_base;
  logic [11:0] r_b_base;
  logic [2:0]  r_type;
  logic [10:0] r_cin, r_cout;
  logic [7:0]  r_in_w, r_in_h, r_out_w, r_out_h;
  logic [1:0]  r_stride;
  logic        w_cfg_bad;

  // Pooling and FC collapse to 1x1; stride 2 rounds the halved size up.
  function automatic logic [7:0] out_dim(input logic [2:0] t, input logic [1:0] s,
                                         input logic [7:0] d);
    logic [8:0] v_sum;
    v_sum = {1'b0, d} + 9'd1;
    if (t == 3'd3 || t == 3'd4) return 8'd1;
    if (s == 2'd2) return v_sum[8:1];
    return d;
  endfunction

  assign w_cfg_bad = (rom_cin == 11'd0) || (rom_cout == 11'd0) ||
                     (rom_stride == 2'd0) || (rom_stride == 2'd3) ||
                     (rom_layer_type > 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_rom_id <= '0;
      r_l_id   <= '0;
      r_w_base <= '0;
      r_b_base <= '0;
      r_type   <= '0;
      r_cin    <= '0;
      r_cout   <= '0;
      r_in_w   <= '0;
      r_in_h   <= '0;
      r_out_w  <= '0;
      r_out_h  <= '0;
      r_stride <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_err    <= 1'b0;
        r_valid  <= 1'b0;
        r_rom_id <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_state  <= S_FETCH;
            r_busy   <= 1'b1;
            r_rom_id <= '0;
          end
          S_FETCH: begin
            // The ROM answers combinationally on r_rom_id, so capture it here.
            r_l_id   <= r_rom_id;
            r_w_base <= rom_w_base;
            r_b_base <= rom_b_base;
            r_type   <= rom_layer_type;
            r_cin    <= rom_cin;
            r_cout   <= rom_cout;
            r_in_w   <= rom_img_w;
            r_in_h   <= rom_img_h;
            r_out_w  <= out_dim(rom_layer_type, rom_stride, rom_img_w);
            r_out_h  <= out_dim(rom_layer_type, rom_stride, rom_img_h);
            r_stride <= rom_stride;
            r_last   <= (r_rom_id == LAST_ID);
            if (w_cfg_bad) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_ISSUE;
              r_valid <= 1'b1;
            end
          end
          S_ISSUE: if (l_ready) begin
            r_state <= S_RUN;
            r_valid <= 1'b0;
          end
          S_RUN: if (l_done) r_state <= S_NEXT;
          S_NEXT: begin
            if (r_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_FETCH;
              r_rom_id <= r_rom_id + 5'd1;
            end
          end
          S_DONE: begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_rom_id <= '0;
          end
          S_ERR: if (start) begin
            r_state  <= S_FETCH;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_rom_id <= '0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign rom_id   = r_rom_id;
  assign l_valid  = r_valid;
  assign l_id     = r_l_id;
  assign l_w_base = r_w_base;
  assign l_b_base = r_b_base;
  assign l_type   = r_type;
  assign l_cin    = r_cin;
  assign l_cout   = r_cout;
  assign l_in_w   = r_in_w;
  assign l_in_h   = r_in_h;
  assign l_out_w  = r_out_w;
  assign l_out_h  = r_out_h;
  assign l_stride = r_stride;
  assign l_last   = r_last;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: MobileNet-style ROM stub with fault injection, a
// cycle-driven engine model, and a descriptor scoreboard.
module tb_layer_sequencer;

  typedef struct packed {
    logic [4:0]  id;
    logic [19:0] wb;
    logic [11:0] bb;
    logic [2:0]  t;
    logic [10:0] cin;
    logic [10:0] cout;
    logic [7:0]  iw;
    logic [7:0]  ih;
    logic [7:0]  ow;
    logic [7:0]  oh;
    logic [1:0]  s;
    logic        last;
  } desc_t;

  localparam int LT [29] = '{0, 1,2,1,2,1,2,1,2,1,2,1,2, 1,2,1,2,1,2,1,2,1,2, 1,2,1,2, 3,4};
  localparam int LC [29] = '{3,32,32,64,64,128,128,128,128,256,256,256,256,
                             512,512,512,512,512,512,512,512,512,512,
                             512,512,1024,1024,1024,1024};
  localparam int LO [29] = '{32,32,64,64,128,128,128,128,256,256,256,256,512,
                             512,512,512,512,512,512,512,512,512,512,
                             512,1024,1024,1024,1024,1000};
  localparam int LI [29] = '{224,112,112,112,56,56,56,56,28,28,28,28,14,
                             14,14,14,14,14,14,14,14,14,14,
                             14,7,7,7,7,1};
  localparam int LS [29] = '{2,1,1,2,1,1,1,2,1,1,1,2,1,
                             1,1,1,1,1,1,1,1,1,1,
                             2,1,1,1,1,1};

  logic        clk, rst_n, start, abort, busy, done, err, l_valid, l_ready, l_done, l_last;
  logic [4:0]  rom_id, l_id;
  logic [19:0] rom_w_base, l_w_base;
  logic [11:0] rom_b_base, l_b_base;
  logic [2:0]  rom_layer_type, l_type;
  logic [10:0] rom_cin, rom_cout, l_cin, l_cout;
  logic [7:0]  rom_img_w, rom_img_h, l_in_w, l_in_h, l_out_w, l_out_h;
  logic [1:0]  rom_stride, l_stride;

  int    errors, checks, bad_id, bad_kind, code, cyc;
  bit    odd_in;
  desc_t rom_d;
  desc_t sb[$];

  layer_sequencer #(.NUM_LAYERS(29)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .rom_id(rom_id),
    .rom_w_base(rom_w_base), .rom_b_base(rom_b_base), .rom_layer_type(rom_layer_type),
    .rom_cin(rom_cin), .rom_cout(rom_cout), .rom_img_w(rom_img_w), .rom_img_h(rom_img_h),
    .rom_stride(rom_stride), .l_valid(l_valid), .l_ready(l_ready), .l_done(l_done),
    .l_id(l_id), .l_w_base(l_w_base), .l_b_base(l_b_base), .l_type(l_type),
    .l_cin(l_cin), .l_cout(l_cout), .l_in_w(l_in_w), .l_in_h(l_in_h),
    .l_out_w(l_out_w), .l_out_h(l_out_h), .l_stride(l_stride), .l_last(l_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer table plus optional faults; also yields the expected descriptor.
  function automatic desc_t model(input int id, input int bid, input int bk, input bit odd);
    desc_t d;
    int k;
    k = (id >= 0 && id < 29) ? id : 0;
    d.id   = 5'(k);
    d.wb   = 20'(k * 4096 + 17);
    d.bb   = 12'(k * 64 + 3);
    d.t    = 3'(LT[k]);
    d.cin  = 11'(LC[k]);
    d.cout = 11'(LO[k]);
    d.iw   = 8'(LI[k]);
    d.ih   = 8'(LI[k]);
    d.s    = 2'(LS[k]);
    if (odd && k == 0) begin
      d.iw = 8'd223;
      d.ih = 8'd9;
    end
    if (k == bid) begin
      case (bk)
        0: d.s = 2'd0;
        1: d.s = 2'd3;
        2: d.cin = 11'd0;
        3: d.cout = 11'd0;
        default: d.t = 3'd5;
      endcase
    end
    if (d.t == 3'd3 || d.t == 3'd4) begin
      d.ow = 8'd1;
      d.oh = 8'd1;
    end else if (d.s == 2'd0) begin
      d.ow = 8'd0;
      d.oh = 8'd0;
    end else begin
      d.ow = 8'((int'(d.iw) + int'(d.s) - 1) / int'(d.s));
      d.oh = 8'((int'(d.ih) + int'(d.s) - 1) / int'(d.s));
    end
    d.last = (k == 28);
    return d;
  endfunction

  always_comb rom_d = model(int'(rom_id), bad_id, bad_kind, odd_in);
  assign rom_w_base     = rom_d.wb;
  assign rom_b_base     = rom_d.bb;
  assign rom_layer_type = rom_d.t;
  assign rom_cin        = rom_d.cin;
  assign rom_cout       = rom_d.cout;
  assign rom_img_w      = rom_d.iw;
  assign rom_img_h      = rom_d.ih;
  assign rom_stride     = rom_d.s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_desc(input desc_t e);
    chk("l_id", l_id, e.id);
    chk("l_w_base", l_w_base, e.wb);
    chk("l_b_base", l_b_base, e.bb);
    chk("l_type", l_type, e.t);
    chk("l_cin", l_cin, e.cin);
    chk("l_cout", l_cout, e.cout);
    chk("l_in_w", l_in_w, e.iw);
    chk("l_in_h", l_in_h, e.ih);
    chk("l_out_w", l_out_w, e.ow);
    chk("l_out_h", l_out_h, e.oh);
    chk("l_stride", l_stride, e.s);
    chk("l_last", l_last, e.last);
  endtask

  // Literal spot values for the layers the network is known by.
  task automatic spot();
    case (int'(l_id))
      0: begin
        chk("l0_out_w", l_out_w, 112);
        chk("l0_stride", l_stride, 2);
      end
      3: begin
        chk("l3_cin", l_cin, 64);
        chk("l3_in_w", l_in_w, 112);
        chk("l3_out_w", l_out_w, 56);
        chk("l3_out_h", l_out_h, 56);
      end
      27: begin
        chk("l27_type", l_type, 3);
        chk("l27_in_w", l_in_w, 7);
        chk("l27_out_w", l_out_w, 1);
        chk("l27_last", l_last, 0);
      end
      28: begin
        chk("l28_cin", l_cin, 1024);
        chk("l28_cout", l_cout, 1000);
        chk("l28_last", l_last, 1);
      end
      default: ;
    endcase
  endtask

  task automatic push_to(input int hi);
    for (int i = 0; i <= hi; i++) sb.push_back(model(i, bad_id, bad_kind, odd_in));
  endtask

  // Starts a run at the current negedge and plays the engine until done/err/abort/reset.
  // code: 0 done, 1 err, 2 abort, 3 reset, 4 timeout. cyc: cycles after the start cycle.
  task automatic run_net(input int stall_id, input int stall_n, input int spur_id,
                         input int start_id, input int abort_id, input int rst_id,
                         output int rc, output int rcyc);
    int dly, left, run_id;
    bit fin, ab_pend;
    desc_t e;
    dly = 0; left = stall_n; run_id = -1; fin = 0; ab_pend = 0; rc = 4; rcyc = 0;
    start = 1'b1;
    while (!fin && rcyc < 400) begin
      @(negedge clk);
      rcyc++;
      start = 1'b0;
      abort = 1'b0;
      if (ab_pend) begin
        chk("abort_busy", busy, 0);
        chk("abort_valid", l_valid, 0);
        chk("abort_rom_id", rom_id, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        rc = 2; fin = 1;
      end else if (done) begin
        rc = 0; fin = 1;
      end else if (err) begin
        rc = 1; fin = 1;
      end else begin
        if (rcyc == 1) begin
          chk("fetch_busy", busy, 1);
          chk("fetch_valid", l_valid, 0);
          chk("fetch_err", err, 0);
          chk("fetch_rom_id", rom_id, 0);
        end
        if (rcyc == 2) chk("first_valid", l_valid, 1);
        l_done = 1'b0;
        if (dly > 0) begin
          dly--;
          if (dly == 0) l_done = 1'b1;
          else begin
            if (run_id == abort_id) begin
              abort = 1'b1;
              ab_pend = 1;
            end
            if (run_id == start_id) start = 1'b1;
          end
        end
        l_ready = 1'b1;
        if (l_valid) begin
          if (int'(l_id) == rst_id) begin
            rst_n = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_valid", l_valid, 0);
            chk("rst_last", l_last, 0);
            chk("rst_rom_id", rom_id, 0);
            chk("rst_l_id", l_id, 0);
            chk("rst_cin", l_cin, 0);
            chk("rst_w_base", l_w_base, 0);
            chk("rst_out_w", l_out_w, 0);
            if (sb.size() != 0) void'(sb.pop_front());
            @(negedge clk);
            rst_n = 1'b1;
            rc = 3; fin = 1;
          end else if (int'(l_id) == stall_id && left > 0) begin
            left--;
            l_ready = 1'b0;
            if (sb.size() != 0) chk_desc(sb[0]);
            spot();
            if (int'(l_id) == spur_id) l_done = 1'b1;
          end else begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              chk_desc(e);
            end
            spot();
            dly = 2;
            run_id = int'(l_id);
          end
        end
      end
    end
    l_done = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    l_ready = 1'b1;
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_width", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rom_id", rom_id, 0);
  endtask

  task automatic full_run(input string tag);
    push_to(28);
    run_net(-1, 0, -1, -1, -1, -1, code, cyc);
    chk({tag, "_code"}, code, 0);
    // done lands 147 cycles from the start cycle, counting both ends.
    chk({tag, "_done_cycle"}, cyc, 146);
    chk({tag, "_sb_left"}, sb.size(), 0);
    after_done();
  endtask

  initial begin
    errors = 0; checks = 0; bad_id = -1; bad_kind = 0; odd_in = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; l_ready = 1'b1; l_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_valid", l_valid, 0);
    chk("reset_last", l_last, 0);
    chk("reset_rom_id", rom_id, 0);
    chk("reset_l_id", l_id, 0);
    chk("reset_cin", l_cin, 0);
    chk("reset_out_w", l_out_w, 0);
    rst_n = 1'b1;
    @(negedge clk);

    full_run("full");

    push_to(28);
    run_net(3, 5, -1, -1, -1, -1, code, cyc);
    chk("stall_code", code, 0);
    chk("stall_done_cycle", cyc, 151);
    chk("stall_sb_left", sb.size(), 0);
    after_done();

    bad_id = 5; bad_kind = 0;
    push_to(4);
    run_net(-1, 0, -1, -1, -1, -1, code, cyc);
    chk("err_code", code, 1);
    chk("err_sb_left", sb.size(), 0);
    chk("err_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_no_valid", l_valid, 0);
      chk("err_sticky", err, 1);
    end
    bad_id = -1;
    full_run("restart");

    push_to(13);
    run_net(-1, 0, -1, -1, 13, -1, code, cyc);
    chk("abort_code", code, 2);
    chk("abort_sb_left", sb.size(), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    full_run("post_abort");

    push_to(28);
    run_net(7, 2, 7, 9, -1, -1, code, cyc);
    chk("spur_code", code, 0);
    chk("spur_done_cycle", cyc, 148);
    chk("spur_sb_left", sb.size(), 0);
    after_done();

    push_to(20);
    run_net(-1, 0, -1, -1, -1, 20, code, cyc);
    chk("rst_code", code, 3);
    chk("rst_sb_left", sb.size(), 0);
    full_run("post_rst");

    bad_id = 1; bad_kind = 3;
    push_to(0);
    run_net(-1, 0, -1, -1, -1, -1, code, cyc);
    chk("cout0_code", code, 1);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_err", err, 0);
    chk("abort_wins_busy", busy, 0);
    @(negedge clk);
    chk("abort_wins_stay_idle", busy, 0);

    bad_id = 0; bad_kind = 4;
    run_net(-1, 0, -1, -1, -1, -1, code, cyc);
    chk("type5_code", code, 1);
    chk("type5_no_valid", l_valid, 0);
    bad_id = 2; bad_kind = 1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("err_abort_clear", err, 0);
    push_to(1);
    run_net(-1, 0, -1, -1, -1, -1, code, cyc);
    chk("stride3_code", code, 1);
    chk("stride3_sb_left", sb.size(), 0);
    bad_id = 2; bad_kind = 2;
    push_to(1);
    run_net(-1, 0, -1, -1, -1, -1, code, cyc);
    chk("cin0_code", code, 1);
    chk("cin0_sb_left", sb.size(), 0);
    bad_id = -1;

    odd_in = 1;
    full_run("odd");
    odd_in = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
